gpio_mulpop: RTL and testbench

Bus-mapped arithmetic peripheral on the GPIO emulator bus. It takes two DW-bit operands, computes their product with a sequential shift-add multiplier (one operand bit per clock), then counts the ones in the 32-bit result. It reports result, popcount and status through bus reads, and exposes a completed-operation counter on `gpio_out`. This is the parametrised successor of the fixed 24-bit multiply/popcount unit; it adds a width parameter, a relocatable register base, a busy flag and a rejected-start error flag.

---
 rtl/gpio_mulpop.sv | 180 ++++++++++++++++++
 tb/tb_gpio_mulpop.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_mulpop.sv
// Bus-mapped unsigned shift-add multiplier that also counts the ones in the low product word.
// Result, popcount and status are read over the emulator bus; gpio_out shows completed operations.
module gpio_mulpop #(
    parameter int          DW    = 24,
    parameter logic [15:0] BASE  = 16'h0380,
    parameter int          CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_in_s_insp,
    output logic [31:0] gpio_out
);
    localparam int PW = 2 * DW;
    localparam int IW = $clog2(DW);

    localparam logic [15:0] ADDR_A1 = BASE;
    localparam logic [15:0] ADDR_A2 = BASE + 16'h0008;
    localparam logic [15:0] ADDR_W  = BASE + 16'h0010;
    localparam logic [15:0] ADDR_L  = BASE + 16'h0018;
    localparam logic [15:0] ADDR_CS = BASE + 16'h0020;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_POP, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_srd_d;
    logic             r_swr_d;
    logic [DW-1:0]    r_a1;
    logic [DW-1:0]    r_a2;
    logic [DW-1:0]    r_a1_snap;
    logic [DW-1:0]    r_a2_snap;
    logic [PW-1:0]    r_acc;
    logic [IW-1:0]    r_idx;
    logic [31:0]      r_w;
    logic [5:0]       r_l;
    logic             r_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_sdata_out;
    logic [31:0]      r_gpio_cap;

    logic             w_rd;
    logic             w_wr;
    logic             w_start;
    logic             w_err_evt;
    logic             w_busy;
    logic [PW-1:0]    w_addend;
    logic [63:0]      w_acc64;
    logic [31:0]      w_acc_lo;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_data;
    logic             w_unused_sdata;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int k = 0; k < 32; k++) n = n + {5'b0, v[k]};
        return n;
    endfunction

    function automatic logic fits_32(input logic [63:0] p);
        return p[63:32] == 32'd0;
    endfunction

    // Operand bits above DW are ignored on A1/A2 writes.
    assign w_unused_sdata = ^sdata_in;

    assign w_rd      = srd & ~r_srd_d;
    assign w_wr      = swr & ~r_swr_d;
    assign w_busy    = (r_state != S_IDLE);
    assign w_start   = w_wr && (saddress == ADDR_CS) && (r_state == S_IDLE);
    assign w_err_evt = w_wr && (saddress == ADDR_CS) && (r_state != S_IDLE);

    assign w_addend = r_a2_snap[r_idx] ? (PW'(r_a1_snap) << r_idx) : '0;
    assign w_acc64  = 64'(r_acc);
    assign w_acc_lo = w_acc64[31:0];
    assign w_status = {28'b0, r_err, w_busy, ~w_busy, r_valid};

    always_comb begin
        w_rd_data = '0;
        if (saddress == ADDR_W)       w_rd_data = r_w;
        else if (saddress == ADDR_L)  w_rd_data = {26'b0, r_l};
        else if (saddress == ADDR_CS) w_rd_data = w_status;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_MULT;
            S_MULT:  if (r_idx == IW'(DW - 1)) w_state_nxt = S_POP;
            S_POP:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_srd_d <= 1'b0;
            r_swr_d <= 1'b0;
            r_a1    <= '0;
            r_a2    <= '0;
        end else begin
            r_srd_d <= srd;
            r_swr_d <= swr;
            if (w_wr && saddress == ADDR_A1) r_a1 <= sdata_in[DW-1:0];
            if (w_wr && saddress == ADDR_A2) r_a2 <= sdata_in[DW-1:0];
        end
    end

    // Datapath: snapshot on start, one multiplier bit per MULT clock, publish in POP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a1_snap <= '0;
            r_a2_snap <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_w       <= '0;
            r_l       <= '0;
            r_valid   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_a1_snap <= r_a1;
                        r_a2_snap <= r_a2;
                        r_acc     <= '0;
                        r_idx     <= '0;
                    end
                end
                S_MULT: begin
                    r_acc <= r_acc + w_addend;
                    r_idx <= r_idx + 1'b1;
                end
                S_POP: begin
                    r_w     <= w_acc_lo;
                    r_l     <= popcount32(w_acc_lo);
                    r_valid <= fits_32(w_acc64);
                end
                default: ;
            endcase
        end
    end

    // A rejected start in the same clock as a STATUS read leaves err set.
    always_ff @(posedge clk) begin
        if (reset)                           r_err <= 1'b0;
        else if (w_err_evt)                  r_err <= 1'b1;
        else if (w_rd && saddress == ADDR_CS) r_err <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_sdata_out <= '0;
            r_gpio_cap  <= '0;
        end else begin
            if (r_state == S_DONE) r_cnt <= r_cnt + 1'b1;
            if (w_rd)              r_sdata_out <= w_rd_data;
            if (gpio_latch)        r_gpio_cap <= gpio_in;
        end
    end

    assign sdata_out      = r_sdata_out;
    assign gpio_in_s_insp = r_gpio_cap;
    assign gpio_out       = 32'(r_cnt);

endmodule

// File: tb/tb_gpio_mulpop.sv
// Bench for gpio_mulpop: a DW=24 and a DW=8 instance on separate strobes, checked against
// constant vectors and a timed product/popcount reference model.
`timescale 1ns/1ps
module tb_gpio_mulpop;
    localparam logic [15:0] BASE  = 16'h0380;
    localparam logic [15:0] AD_A1 = BASE;
    localparam logic [15:0] AD_A2 = BASE + 16'h0008;
    localparam logic [15:0] AD_W  = BASE + 16'h0010;
    localparam logic [15:0] AD_L  = BASE + 16'h0018;
    localparam logic [15:0] AD_CS = BASE + 16'h0020;
    localparam logic [15:0] AD_NX = BASE + 16'h0028;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] saddress = '0;
    logic [31:0] sdata_in = '0;
    logic [31:0] gpio_in = '0;
    logic        gpio_latch = 1'b0;
    logic        srd0 = 1'b0, swr0 = 1'b0, srd1 = 1'b0, swr1 = 1'b0;
    logic [31:0] sdo0, sdo1, ins0, ins1, go0, go1;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_mulpop #(.DW(24)) dut0 (
        .clk(clk), .reset(reset), .saddress(saddress), .srd(srd0), .swr(swr0),
        .sdata_in(sdata_in), .sdata_out(sdo0), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
        .gpio_in_s_insp(ins0), .gpio_out(go0)
    );

    gpio_mulpop #(.DW(8)) dut1 (
        .clk(clk), .reset(reset), .saddress(saddress), .srd(srd1), .swr(swr1),
        .sdata_in(sdata_in), .sdata_out(sdo1), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
        .gpio_in_s_insp(ins1), .gpio_out(go1)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: one pending operation per instance, results keyed to clock edge numbers.
    int          m_dw [2] = '{24, 8};
    logic [31:0] m_a1 [2], m_a2 [2], m_s1 [2], m_s2 [2], m_w [2], m_last [2];
    int          m_l [2], m_cnt [2], m_t [2];
    logic        m_valid [2], m_err [2], m_pend_res [2], m_pend_cnt [2];

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] w;
        logic [31:0] l;
        logic [31:0] st;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sdo(input int d);
        return (d == 0) ? sdo0 : sdo1;
    endfunction

    function automatic logic [31:0] gout(input int d);
        return (d == 0) ? go0 : go1;
    endfunction

    function automatic logic [31:0] opmask(input int d);
        return (m_dw[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_dw[d]) - 32'd1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_a1[d] = '0; m_a2[d] = '0; m_s1[d] = '0; m_s2[d] = '0;
            m_w[d] = '0; m_last[d] = '0; m_l[d] = 0; m_cnt[d] = 0; m_t[d] = 0;
            m_valid[d] = 1'b1; m_err[d] = 1'b0;
            m_pend_res[d] = 1'b0; m_pend_cnt[d] = 1'b0;
        end
    endtask

    // Bring the model to the state observed just after edge k.
    task automatic advance(input int d, input int k);
        logic [63:0] prod;
        if (m_pend_res[d] && k >= m_t[d] + m_dw[d] + 1) begin
            prod = 64'(m_s1[d]) * 64'(m_s2[d]);
            m_w[d] = prod[31:0];
            m_l[d] = $countones(prod[31:0]);
            m_valid[d] = (prod[63:32] == 32'd0);
            m_pend_res[d] = 1'b0;
        end
        if (m_pend_cnt[d] && k >= m_t[d] + m_dw[d] + 2) begin
            m_cnt[d] = (m_cnt[d] + 1) & 32'hFFFF;
            m_pend_cnt[d] = 1'b0;
        end
    endtask

    function automatic logic m_busy(input int d, input int k);
        return m_pend_cnt[d] && k >= m_t[d];
    endfunction

    task automatic model_wr(input int d, input logic [15:0] a, input logic [31:0] v, input int e);
        advance(d, e - 1);
        if (a == AD_A1) m_a1[d] = v & opmask(d);
        else if (a == AD_A2) m_a2[d] = v & opmask(d);
        else if (a == AD_CS) begin
            if (m_busy(d, e - 1)) m_err[d] = 1'b1;
            else begin
                m_s1[d] = m_a1[d]; m_s2[d] = m_a2[d]; m_t[d] = e;
                m_pend_res[d] = 1'b1; m_pend_cnt[d] = 1'b1;
            end
        end
    endtask

    task automatic model_rd(input int d, input logic [15:0] a, input int e, output logic [31:0] exp);
        logic b;
        advance(d, e - 1);
        b = m_busy(d, e - 1);
        exp = '0;
        if (a == AD_W) exp = m_w[d];
        else if (a == AD_L) exp = 32'(m_l[d]);
        else if (a == AD_CS) begin
            exp = {28'b0, m_err[d], b, ~b, m_valid[d]};
            m_err[d] = 1'b0;
        end
        m_last[d] = exp;
    endtask

    task automatic set_strobe(input int d, input logic rd, input logic wr);
        if (d == 0) begin srd0 = rd; swr0 = wr; end
        else        begin srd1 = rd; swr1 = wr; end
    endtask

    task automatic wr(input int d, input logic [15:0] a, input logic [31:0] v);
        @(negedge clk);
        saddress = a; sdata_in = v; set_strobe(d, 1'b0, 1'b1);
        @(negedge clk);
        set_strobe(d, 1'b0, 1'b0);
        model_wr(d, a, v, cyc);
    endtask

    task automatic rd_raw(input int d, input logic [15:0] a, output logic [31:0] v, output logic [31:0] exp);
        @(negedge clk);
        saddress = a; set_strobe(d, 1'b1, 1'b0);
        @(negedge clk);
        set_strobe(d, 1'b0, 1'b0);
        v = sdo(d);
        model_rd(d, a, cyc, exp);
    endtask

    task automatic rd_chk(input int d, input logic [15:0] a, input string name, output logic [31:0] v);
        logic [31:0] exp;
        rd_raw(d, a, v, exp);
        check(name, v, exp);
    endtask

    // STATUS read and CTRL write on the same edge.
    task automatic rdwr_cs(input int d, input string name);
        logic [31:0] v, exp, wd;
        wd = $urandom;
        @(negedge clk);
        saddress = AD_CS; sdata_in = wd; set_strobe(d, 1'b1, 1'b1);
        @(negedge clk);
        set_strobe(d, 1'b0, 1'b0);
        v = sdo(d);
        model_rd(d, AD_CS, cyc, exp);
        model_wr(d, AD_CS, wd, cyc);
        check(name, v, exp);
    endtask

    task automatic chk_gpio(input int d, input string name);
        advance(d, cyc);
        check(name, gout(d), 32'(m_cnt[d]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, exp;

        tbl[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 32'd4,  32'h3};
        tbl[1] = '{32'h0000_0000, 32'h0000_0123, 32'h0000_0000, 32'd0,  32'h3};
        tbl[2] = '{32'h0000_1000, 32'h0000_1000, 32'h0100_0000, 32'd1,  32'h3};
        tbl[3] = '{32'h00FF_FFFF, 32'h0000_0001, 32'h00FF_FFFF, 32'd24, 32'h3};
        tbl[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'd0,  32'h2};
        tbl[5] = '{32'hAB00_0003, 32'hFF00_0007, 32'h0000_0015, 32'd3,  32'h3};
        tbl[6] = '{32'h00FF_FFFF, 32'h00FF_FFFF, 32'hFE00_0001, 32'd8,  32'h2};

        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("reset sdata_out0", sdo0, 32'h0);
        check("reset gpio_out0", go0, 32'h0);
        check("reset insp0", ins0, 32'h0);
        check("reset sdata_out1", sdo1, 32'h0);
        check("reset gpio_out1", go1, 32'h0);
        rd_chk(0, AD_CS, "reset STATUS", v);
        check("reset STATUS literal", v, 32'h3);
        rd_chk(0, AD_W, "reset W", v);
        rd_chk(0, AD_L, "reset L", v);
        rd_chk(1, AD_CS, "reset STATUS dw8", v);

        for (int i = 0; i < 7; i++) begin
            wr(0, AD_A1, tbl[i].a1);
            wr(0, AD_A2, tbl[i].a2);
            wr(0, AD_CS, 32'h1);
            repeat (m_dw[0] + 3) @(negedge clk);
            rd_raw(0, AD_W, v, exp);
            check($sformatf("tbl[%0d] W", i), v, tbl[i].w);
            rd_raw(0, AD_L, v, exp);
            check($sformatf("tbl[%0d] L", i), v, tbl[i].l);
            rd_raw(0, AD_CS, v, exp);
            check($sformatf("tbl[%0d] STATUS", i), v, tbl[i].st);
            check($sformatf("tbl[%0d] gpio_out", i), go0, 32'(i + 1));
        end

        // Rejected start, then STATUS and W observed mid-operation.
        wr(0, AD_A1, 32'h3);
        wr(0, AD_A2, 32'h5);
        wr(0, AD_CS, 32'h0);
        repeat (3) @(negedge clk);
        wr(0, AD_CS, 32'hFFFF_FFFF);
        rd_chk(0, AD_W, "busy W held", v);
        rd_chk(0, AD_CS, "busy STATUS err", v);
        repeat (m_dw[0] + 3) @(negedge clk);
        rd_chk(0, AD_CS, "after err cleared", v);
        chk_gpio(0, "busy gpio_out");

        // Rejected start left pending until after completion.
        wr(0, AD_A1, 32'hFF_FFFF);
        wr(0, AD_A2, 32'hFF_FFFF);
        wr(0, AD_CS, 32'h0);
        repeat (3) @(negedge clk);
        wr(0, AD_CS, 32'h0);
        repeat (m_dw[0] + 3) @(negedge clk);
        rd_chk(0, AD_CS, "err sticky STATUS", v);
        check("err sticky literal", v, 32'hA);
        rd_chk(0, AD_CS, "err cleared STATUS", v);
        check("err cleared literal", v, 32'h2);
        chk_gpio(0, "single count");

        // Simultaneous STATUS read with start, then with a rejected start.
        rdwr_cs(0, "rd+start pre-status");
        repeat (2) @(negedge clk);
        rdwr_cs(0, "rd+reject pre-status");
        rd_chk(0, AD_CS, "err wins over clear", v);
        repeat (m_dw[0] + 3) @(negedge clk);
        chk_gpio(0, "simul gpio_out");

        // DW=8 instance: exact completion latency and GPIO capture.
        wr(1, AD_A1, 32'hFF);
        wr(1, AD_A2, 32'hFF);
        wr(1, AD_CS, 32'h1);
        repeat (m_dw[1] + 1) @(negedge clk);
        chk_gpio(1, "dw8 count before done");
        @(negedge clk);
        chk_gpio(1, "dw8 count at done");
        rd_chk(1, AD_W, "dw8 W", v);
        check("dw8 W literal", v, 32'h0000_FE01);
        rd_chk(1, AD_L, "dw8 L", v);
        rd_chk(1, AD_CS, "dw8 STATUS", v);
        @(negedge clk);
        gpio_in = 32'hA5A5_A5A5; gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0; gpio_in = 32'h1234_5678;
        @(negedge clk);
        check("gpio capture0", ins0, 32'hA5A5_A5A5);
        check("gpio capture1", ins1, 32'hA5A5_A5A5);

        for (int r = 0; r < 24; r++) begin
            int d;
            d = (r % 3 == 2) ? 1 : 0;
            wr(d, AD_A1, $urandom);
            wr(d, AD_A2, (r % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom);
            wr(d, AD_CS, $urandom);
            if (r % 2 == 1) wr(d, AD_A1, $urandom);
            if (r % 5 == 0) rd_chk(d, AD_W, "rnd W mid-op", v);
            repeat (m_dw[d] + 3) @(negedge clk);
            rd_chk(d, AD_W, "rnd W", v);
            rd_chk(d, AD_L, "rnd L", v);
            rd_chk(d, AD_CS, "rnd STATUS", v);
            chk_gpio(d, "rnd gpio_out");
            rd_chk(d, (r % 2 == 0) ? AD_NX : AD_A2, "rnd unmapped", v);
        end

        rd_chk(0, AD_L, "hold setup", v);
        wr(0, AD_A1, 32'h55);
        repeat (3) @(negedge clk);
        check("sdata_out hold", sdo0, m_last[0]);

        // Reset in the middle of MULT discards the operation.
        wr(0, AD_A1, 32'h7);
        wr(0, AD_A2, 32'h9);
        wr(0, AD_CS, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("midrst gpio_out", go0, 32'h0);
        check("midrst sdata_out", sdo0, 32'h0);
        rd_chk(0, AD_W, "midrst W", v);
        rd_chk(0, AD_L, "midrst L", v);
        rd_chk(0, AD_CS, "midrst STATUS", v);
        check("midrst STATUS literal", v, 32'h3);
        repeat (m_dw[0] + 3) @(negedge clk);
        chk_gpio(0, "midrst no late count");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
